// File: rtl/asyfifo_pkg.sv
// asyfifo_pkg: shared widths, uio bit positions and gray-code helper
package asyfifo_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int WR_EN_BIT = 0;
    localparam int RD_EN_BIT = 1;
    localparam int FULL_BIT = 2;
    localparam int EMPTY_BIT = 3;
    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/asyfifo_if.sv
// asyfifo_if: tile-facing pins of the FIFO grouped as one bus
interface asyfifo_if;
    import asyfifo_pkg::*;
    logic ena;
    logic [DATA_W-1:0] ui_in;
    logic [7:0] uio_in;
    logic [DATA_W-1:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/asyfifo_sync2.sv
// asyfifo_sync2: two-flop pointer synchronizer with synchronous reset
module asyfifo_sync2 #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q1, r_q2;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= i_d;
            r_q2 <= r_q1;
        end
    end
    assign o_q = r_q2;
endmodule

// File: rtl/asyfifo.sv
// asyfifo: 16x8 gray-pointer FIFO with both pointer domains on one clock
module asyfifo
    import asyfifo_pkg::*;
(
    input  logic clk,
    input  logic rst,
    asyfifo_if.slave bus
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout;
    logic [ADDR_W:0] r_wbin, r_wgray, r_rbin, r_rgray;
    logic [ADDR_W:0] w_wq2, w_rq2, w_wbin_nx, w_rbin_nx;
    logic w_full, w_empty, w_wr, w_rd;

    asyfifo_sync2 #(.W(ADDR_W + 1)) u_w2r (.clk(clk), .rst(rst), .i_d(r_wgray), .o_q(w_wq2));
    asyfifo_sync2 #(.W(ADDR_W + 1)) u_r2w (.clk(clk), .rst(rst), .i_d(r_rgray), .o_q(w_rq2));

    // full when the write pointer leads the synced read pointer by exactly DEPTH
    assign w_full = r_wgray == {~w_rq2[ADDR_W:ADDR_W-1], w_rq2[ADDR_W-2:0]};
    assign w_empty = r_rgray == w_wq2;
    assign w_wr = bus.ena & bus.uio_in[WR_EN_BIT] & ~w_full;
    assign w_rd = bus.ena & bus.uio_in[RD_EN_BIT] & ~w_empty;
    assign w_wbin_nx = r_wbin + (ADDR_W + 1)'(1);
    assign w_rbin_nx = r_rbin + (ADDR_W + 1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbin <= '0;
            r_wgray <= '0;
            r_rbin <= '0;
            r_rgray <= '0;
            r_dout <= '0;
        end else begin
            if (w_wr) begin
                r_wbin <= w_wbin_nx;
                r_wgray <= bin2gray(w_wbin_nx);
            end
            if (w_rd) begin
                r_rbin <= w_rbin_nx;
                r_rgray <= bin2gray(w_rbin_nx);
                r_dout <= r_mem[r_rbin[ADDR_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk)
        if (w_wr && !rst) r_mem[r_wbin[ADDR_W-1:0]] <= bus.ui_in;

    assign bus.uo_out = r_dout;
    assign bus.uio_oe = 8'b1111_1100;
    always_comb begin
        bus.uio_out = '0;
        bus.uio_out[FULL_BIT] = w_full;
        bus.uio_out[EMPTY_BIT] = w_empty;
    end
endmodule

// File: tb/tb_asyfifo.sv
// tb_asyfifo: directed vector table, corner sequences and random run against a count-based model
module tb_asyfifo;
    import asyfifo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    asyfifo_if bus ();
    asyfifo dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    // model: byte queue plus total write/read counts and their 2-edge-old copies
    logic [7:0] q[$];
    logic [7:0] m_out = 8'h00;
    int wc = 0, wc1 = 0, wc2 = 0, rc = 0, rc1 = 0, rc2 = 0;

    function automatic bit m_empty();
        return rc == wc2;
    endfunction
    function automatic bit m_full();
        return wc - rc2 == DEPTH;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic w, input logic rd, input logic [7:0] d);
        bit mf, me;
        rst = r;
        bus.ena = e;
        bus.uio_in = {6'b0, rd, w};
        bus.ui_in = d;
        mf = m_full();
        me = m_empty();
        @(posedge clk);
        if (r) begin
            q.delete();
            wc = 0; wc1 = 0; wc2 = 0; rc = 0; rc1 = 0; rc2 = 0;
            m_out = 8'h00;
        end else begin
            wc2 = wc1; wc1 = wc; rc2 = rc1; rc1 = rc;
            if (e && rd && !me) begin
                m_out = q.pop_front();
                rc++;
            end
            if (e && w && !mf) begin
                q.push_back(d);
                wc++;
            end
        end
        #1;
        check("uo_out", bus.uo_out, m_out);
        check("uio_out", bus.uio_out, {4'b0, m_empty(), m_full(), 2'b0});
        check("uio_oe", bus.uio_oe, 8'hFC);
    endtask

    typedef struct {
        logic r, e, w, rd;
        logic [7:0] d, exp_out;
        logic exp_full, exp_empty;
    } vec_t;
    vec_t tv[16];

    initial begin
        bus.ena = 1'b1;
        bus.uio_in = 8'h00;
        bus.ui_in = 8'h00;
        tv[0]  = '{1, 1, 0, 0, 8'h00, 8'h00, 0, 1};
        tv[1]  = '{1, 1, 0, 0, 8'h00, 8'h00, 0, 1};
        tv[2]  = '{1, 1, 0, 1, 8'h00, 8'h00, 0, 1};
        tv[3]  = '{0, 1, 1, 0, 8'hA5, 8'h00, 0, 1};
        tv[4]  = '{0, 1, 0, 0, 8'h00, 8'h00, 0, 1};
        tv[5]  = '{0, 1, 0, 0, 8'h00, 8'h00, 0, 0};
        tv[6]  = '{0, 1, 0, 1, 8'h00, 8'hA5, 0, 1};
        tv[7]  = '{0, 1, 0, 1, 8'h00, 8'hA5, 0, 1};
        tv[8]  = '{0, 1, 1, 0, 8'h3C, 8'hA5, 0, 1};
        tv[9]  = '{0, 1, 0, 0, 8'h00, 8'hA5, 0, 1};
        tv[10] = '{0, 1, 0, 0, 8'h00, 8'hA5, 0, 0};
        tv[11] = '{0, 1, 0, 1, 8'h00, 8'h3C, 0, 1};
        tv[12] = '{0, 0, 1, 0, 8'h77, 8'h3C, 0, 1};
        tv[13] = '{0, 0, 0, 1, 8'h00, 8'h3C, 0, 1};
        tv[14] = '{0, 0, 0, 0, 8'h00, 8'h3C, 0, 1};
        tv[15] = '{0, 0, 1, 1, 8'h55, 8'h3C, 0, 1};

        for (int i = 0; i < 16; i++) begin
            step(tv[i].r, tv[i].e, tv[i].w, tv[i].rd, tv[i].d);
            check($sformatf("vec%0d_out", i), bus.uo_out, tv[i].exp_out);
            check($sformatf("vec%0d_flags", i), bus.uio_out,
                  {4'b0, tv[i].exp_empty, tv[i].exp_full, 2'b0});
        end

        // fill, overflow attempt, drain
        for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 8'h10 + 8'(i));
        check("fill_full", {7'b0, bus.uio_out[FULL_BIT]}, 8'h01);
        step(0, 1, 1, 0, 8'hFF);
        check("overflow_full", {7'b0, bus.uio_out[FULL_BIT]}, 8'h01);
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 1, 8'h00);
            check("drain", bus.uo_out, 8'h10 + 8'(i));
        end
        check("drain_empty", {7'b0, bus.uio_out[EMPTY_BIT]}, 8'h01);
        step(0, 1, 0, 1, 8'h00);
        check("underflow_hold", bus.uo_out, 8'h1F);

        // simultaneous traffic across the pointer wrap
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 8'h40 + 8'(i));
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1, 1, 8'h44 + 8'(i));
            check("simul_out", bus.uo_out, 8'h40 + 8'(i));
            check("simul_nofull", {7'b0, bus.uio_out[FULL_BIT]}, 8'h00);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1, 8'h00);
            check("simul_tail", bus.uo_out, 8'h54 + 8'(i));
        end

        // reset mid-stream discards contents
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 8'h60 + 8'(i));
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 1, 8'h00);
        step(1, 1, 0, 0, 8'h00);
        check("midrst_out", bus.uo_out, 8'h00);
        check("midrst_empty", {7'b0, bus.uio_out[EMPTY_BIT]}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 1, 8'h00);
            check("midrst_noread", bus.uo_out, 8'h00);
        end
        step(0, 1, 1, 0, 8'h99);
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 1, 8'h00);
        check("midrst_new", bus.uo_out, 8'h99);

        // random traffic, write-heavy then read-heavy to visit both flags
        for (int i = 0; i < 3000; i++) begin
            int pw = (i % 600 < 300) ? 75 : 30;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw),
                 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
